piradip_iq_stream_sequencer: RTL and testbench

- Run controller for the IQ sample interleaver.
- Latches a capture mode and beat count, drives the interleaver's i_en/q_en, counts accepted output beats, and flags the last beat with tlast.
- Changes mode only between runs, with a flush window so no partial-mode beat reaches the downstream DMA.
- Sits between the control register block and the interleaver, on the interleaver's output clock.

---
 rtl/piradip_iq_pkg.sv | 19 +
 rtl/piradip_iq_stream_sequencer_if.sv | 29 ++
 rtl/piradip_iq_stream_sequencer.sv | 118 +++++++++++
 tb/tb_piradip_iq_stream_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/piradip_iq_pkg.sv
// rtl/piradip_iq_pkg.sv - shared types and constants for the IQ capture path
package piradip_iq_pkg;

    typedef enum logic [1:0] {
        IQ_OFF = 2'b00,
        IQ_I   = 2'b01,
        IQ_Q   = 2'b10,
        IQ_IQ  = 2'b11
    } iq_mode_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_FLUSH
    } seq_state_t;

    localparam int SAMPLE_WIDTH = 16;

endpackage

// File: rtl/piradip_iq_stream_sequencer_if.sv
// rtl/piradip_iq_stream_sequencer_if.sv - control, monitor and status bundle of the IQ run sequencer
interface piradip_iq_stream_sequencer_if #(
    parameter int COUNT_WIDTH = 32
);
    logic [1:0]             cfg_mode;
    logic [COUNT_WIDTH-1:0] cfg_beats;
    logic                   start;
    logic                   abort;
    logic                   mon_tvalid;
    logic                   mon_tready;
    logic                   i_en;
    logic                   q_en;
    logic                   tlast;
    logic                   busy;
    logic                   done;
    logic                   aborted;
    logic                   cfg_err;
    logic [COUNT_WIDTH-1:0] beat_count;

    modport master (
        output cfg_mode, cfg_beats, start, abort, mon_tvalid, mon_tready,
        input  i_en, q_en, tlast, busy, done, aborted, cfg_err, beat_count
    );

    modport slave (
        input  cfg_mode, cfg_beats, start, abort, mon_tvalid, mon_tready,
        output i_en, q_en, tlast, busy, done, aborted, cfg_err, beat_count
    );
endinterface

// File: rtl/piradip_iq_stream_sequencer.sv
// rtl/piradip_iq_stream_sequencer.sv - run controller for the IQ interleaver
// Latches mode/beat count, gates the interleaver enables, counts beats, flags tlast.
module piradip_iq_stream_sequencer
    import piradip_iq_pkg::*;
#(
    parameter int COUNT_WIDTH  = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic aclk,
    input  logic areset,
    piradip_iq_stream_sequencer_if.slave seq
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    seq_state_t             state_q, state_d;
    iq_mode_t               mode_q, mode_d;
    logic [COUNT_WIDTH-1:0] beats_q, beats_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [FW-1:0]          flush_q, flush_d;
    logic                   i_en_q, i_en_d;
    logic                   q_en_q, q_en_d;
    logic                   done_q, done_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   aborted_q, aborted_d;
    logic                   beat;
    logic                   last;
    logic                   stay_run;

    assign beat = seq.mon_tvalid & seq.mon_tready;
    // beats_q is never zero in RUN, so the subtraction cannot wrap
    assign last = (state_q == SEQ_RUN) && (count_q == beats_q - COUNT_WIDTH'(1));

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        beats_d   = beats_q;
        count_d   = count_q;
        flush_d   = flush_q;
        aborted_d = aborted_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (seq.start) begin
                    if (seq.cfg_mode != IQ_OFF && seq.cfg_beats != '0) begin
                        mode_d    = iq_mode_t'(seq.cfg_mode);
                        beats_d   = seq.cfg_beats;
                        count_d   = '0;
                        aborted_d = 1'b0;
                        state_d   = SEQ_RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            SEQ_RUN: begin
                if (beat) count_d = count_q + COUNT_WIDTH'(1);
                flush_d = FW'(FLUSH_CYCLES - 1);
                // a final beat coinciding with abort completes the run normally
                if (beat && last) begin
                    state_d = SEQ_FLUSH;
                end else if (seq.abort) begin
                    aborted_d = 1'b1;
                    state_d   = SEQ_FLUSH;
                end
            end
            SEQ_FLUSH: begin
                if (flush_q == '0) begin
                    state_d = SEQ_IDLE;
                    done_d  = 1'b1;
                end else begin
                    flush_d = flush_q - FW'(1);
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
        stay_run = (state_q == SEQ_RUN) && (state_d == SEQ_RUN);
        i_en_d   = stay_run & mode_q[0];
        q_en_d   = stay_run & mode_q[1];
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= SEQ_IDLE;
            mode_q    <= IQ_OFF;
            beats_q   <= '0;
            count_q   <= '0;
            flush_q   <= '0;
            i_en_q    <= 1'b0;
            q_en_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            beats_q   <= beats_d;
            count_q   <= count_d;
            flush_q   <= flush_d;
            i_en_q    <= i_en_d;
            q_en_q    <= q_en_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            aborted_q <= aborted_d;
        end
    end

    assign seq.i_en       = i_en_q;
    assign seq.q_en       = q_en_q;
    assign seq.tlast      = last;
    assign seq.busy       = (state_q != SEQ_IDLE);
    assign seq.done       = done_q;
    assign seq.aborted    = aborted_q;
    assign seq.cfg_err    = cfg_err_q;
    assign seq.beat_count = count_q;

endmodule

// File: tb/tb_piradip_iq_stream_sequencer.sv
// tb/tb_piradip_iq_stream_sequencer.sv - directed self-checking bench for the IQ run sequencer
module tb_piradip_iq_stream_sequencer;

    localparam int CW = 8;

    logic aclk;
    logic areset;
    int   n_cmp;
    int   n_fail;

    piradip_iq_stream_sequencer_if #(.COUNT_WIDTH(CW)) sif ();

    piradip_iq_stream_sequencer #(
        .COUNT_WIDTH (CW),
        .FLUSH_CYCLES(2)
    ) dut (
        .aclk  (aclk),
        .areset(areset),
        .seq   (sif.slave)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] mode, input logic [CW-1:0] beats);
        sif.cfg_mode  = mode;
        sif.cfg_beats = beats;
        sif.start     = 1'b1;
        tick();
        sif.start     = 1'b0;
    endtask

    initial begin
        logic tv_pat [5];
        int   cnt_pat [5];
        int   tl_pat [5];
        tv_pat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        cnt_pat = '{1, 1, 2, 2, 3};
        tl_pat  = '{0, 0, 1, 1, 0};
        n_cmp  = 0;
        n_fail = 0;
        areset = 1'b1;
        sif.cfg_mode   = 2'b00;
        sif.cfg_beats  = '0;
        sif.start      = 1'b0;
        sif.abort      = 1'b0;
        sif.mon_tvalid = 1'b0;
        sif.mon_tready = 1'b0;
        tick();
        tick();
        areset = 1'b0;
        tick();

        chk("rst_busy", 32'(sif.busy), 0);
        chk("rst_i_en", 32'(sif.i_en), 0);
        chk("rst_q_en", 32'(sif.q_en), 0);
        chk("rst_done", 32'(sif.done), 0);
        chk("rst_cfg_err", 32'(sif.cfg_err), 0);
        chk("rst_aborted", 32'(sif.aborted), 0);
        chk("rst_tlast", 32'(sif.tlast), 0);
        chk("rst_count", 32'(sif.beat_count), 0);

        // IQ interleaved, 4 beats, continuous flow
        sif.mon_tvalid = 1'b1;
        sif.mon_tready = 1'b1;
        launch(2'b11, 8'd4);
        chk("t1_busy", 32'(sif.busy), 1);
        chk("t1_en_lat", 32'(sif.i_en), 0);
        chk("t1_cnt0", 32'(sif.beat_count), 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("t1_cnt", 32'(sif.beat_count), 32'(k));
            chk("t1_i_en", 32'(sif.i_en), 1);
            chk("t1_q_en", 32'(sif.q_en), 1);
            chk("t1_tlast", 32'(sif.tlast), (k == 3) ? 32'd1 : 32'd0);
        end
        tick();
        chk("t1_cnt4", 32'(sif.beat_count), 4);
        chk("t1_en_drop", 32'({sif.i_en, sif.q_en}), 0);
        chk("t1_tlast_end", 32'(sif.tlast), 0);
        chk("t1_flush_busy", 32'(sif.busy), 1);
        tick();
        chk("t1_flush_done0", 32'(sif.done), 0);
        tick();
        chk("t1_done", 32'(sif.done), 1);
        chk("t1_idle", 32'(sif.busy), 0);
        chk("t1_cnt_flush", 32'(sif.beat_count), 4);
        tick();
        chk("t1_done_pulse", 32'(sif.done), 0);
        chk("t1_cnt_hold", 32'(sif.beat_count), 4);

        // I only, 3 beats, gappy tvalid
        sif.mon_tvalid = 1'b0;
        launch(2'b01, 8'd3);
        for (int k = 0; k < 5; k++) begin
            sif.mon_tvalid = tv_pat[k];
            tick();
            chk("t2_cnt", 32'(sif.beat_count), 32'(cnt_pat[k]));
            chk("t2_tlast", 32'(sif.tlast), 32'(tl_pat[k]));
            if (k == 0) chk("t2_en", 32'({sif.q_en, sif.i_en}), 1);
        end
        chk("t2_en_drop", 32'({sif.q_en, sif.i_en}), 0);
        sif.mon_tvalid = 1'b0;
        tick();
        tick();
        chk("t2_done", 32'(sif.done), 1);

        // rejected starts
        launch(2'b00, 8'd5);
        chk("t3_err_mode", 32'(sif.cfg_err), 1);
        chk("t3_busy_a", 32'(sif.busy), 0);
        tick();
        chk("t3_err_pulse", 32'(sif.cfg_err), 0);
        launch(2'b10, 8'd0);
        chk("t3_err_beats", 32'(sif.cfg_err), 1);
        chk("t3_busy_b", 32'(sif.busy), 0);
        tick();
        chk("t3_en", 32'({sif.q_en, sif.i_en}), 0);
        chk("t3_busy_c", 32'(sif.busy), 0);

        // abort after 10 beats, abort cycle also carries a beat
        sif.mon_tvalid = 1'b1;
        launch(2'b11, 8'd100);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t4_tlast", 32'(sif.tlast), 0);
        end
        chk("t4_cnt10", 32'(sif.beat_count), 10);
        sif.abort = 1'b1;
        tick();
        sif.abort = 1'b0;
        chk("t4_cnt11", 32'(sif.beat_count), 11);
        chk("t4_aborted", 32'(sif.aborted), 1);
        chk("t4_en_drop", 32'({sif.q_en, sif.i_en}), 0);
        tick();
        tick();
        chk("t4_done", 32'(sif.done), 1);
        chk("t4_cnt_final", 32'(sif.beat_count), 11);
        chk("t4_aborted_sticky", 32'(sif.aborted), 1);

        // abort coinciding with final beat completes the run
        launch(2'b01, 8'd2);
        chk("t4b_aborted_clr", 32'(sif.aborted), 0);
        tick();
        chk("t4b_tlast", 32'(sif.tlast), 1);
        sif.abort = 1'b1;
        tick();
        sif.abort = 1'b0;
        chk("t4b_cnt", 32'(sif.beat_count), 2);
        chk("t4b_aborted", 32'(sif.aborted), 0);
        tick();
        tick();
        chk("t4b_done", 32'(sif.done), 1);

        // reset mid-run
        launch(2'b11, 8'd20);
        for (int k = 0; k < 5; k++) tick();
        chk("t5_cnt5", 32'(sif.beat_count), 5);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        chk("t5_busy", 32'(sif.busy), 0);
        chk("t5_en", 32'({sif.q_en, sif.i_en}), 0);
        chk("t5_cnt", 32'(sif.beat_count), 0);
        chk("t5_done", 32'(sif.done), 0);
        tick();
        tick();
        chk("t5_no_done", 32'(sif.done), 0);
        launch(2'b10, 8'd2);
        tick();
        chk("t5_new_en", 32'({sif.q_en, sif.i_en}), 2);
        tick();
        chk("t5_new_cnt", 32'(sif.beat_count), 2);
        tick();
        tick();
        chk("t5_new_done", 32'(sif.done), 1);

        // start during RUN with a different config is ignored
        sif.mon_tvalid = 1'b0;
        launch(2'b01, 8'd3);
        tick();
        launch(2'b10, 8'd1);
        chk("t6_en", 32'({sif.q_en, sif.i_en}), 1);
        chk("t6_cfg_err", 32'(sif.cfg_err), 0);
        chk("t6_busy", 32'(sif.busy), 1);
        sif.mon_tvalid = 1'b1;
        tick();
        chk("t6_tlast1", 32'(sif.tlast), 0);
        tick();
        chk("t6_tlast2", 32'(sif.tlast), 1);
        chk("t6_en_keep", 32'({sif.q_en, sif.i_en}), 1);
        tick();
        chk("t6_cnt", 32'(sif.beat_count), 3);
        tick();
        tick();
        chk("t6_done", 32'(sif.done), 1);

        // maximum beat count, beats during FLUSH not counted
        launch(2'b11, 8'd255);
        for (int k = 0; k < 254; k++) tick();
        chk("t7_cnt254", 32'(sif.beat_count), 254);
        chk("t7_tlast", 32'(sif.tlast), 1);
        tick();
        chk("t7_cnt255", 32'(sif.beat_count), 255);
        chk("t7_tlast_end", 32'(sif.tlast), 0);
        tick();
        tick();
        chk("t7_done", 32'(sif.done), 1);
        chk("t7_cnt_final", 32'(sif.beat_count), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
